// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcodes, control-field layout and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // Bit positions inside ALU_control_i = {invertA, invertB, op[1:0]}
  localparam int CTRL_INV_A  = 3;
  localparam int CTRL_INV_B  = 2;
  localparam int CTRL_OP_MSB = 1;
  localparam int CTRL_OP_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // ADD and SLT share the adder path and produce carry/overflow flags.
  function automatic logic isArith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-wide slice: optional operand inversion, AND/OR or add with carry-in.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             invertA,
  input  logic             invertB,
  input  logic [1:0]       op,
  input  logic             carryIn,
  output logic [DIGIT-1:0] result,
  output logic             carryOut,
  output logic             carryTop
);

  logic [DIGIT-1:0] aMod_s;
  logic [DIGIT-1:0] bMod_s;
  logic [DIGIT:0]   sum_s;

  // Operand conditioning and digit adder
  always_comb begin
    aMod_s   = invertA ? ~a : a;
    bMod_s   = invertB ? ~b : b;
    sum_s    = {1'b0, aMod_s} + {1'b0, bMod_s} + {{DIGIT{1'b0}}, carryIn};
    carryOut = sum_s[DIGIT];
    // Carry into the top bit falls out of the top sum bit and its two addends.
    carryTop = sum_s[DIGIT-1] ^ aMod_s[DIGIT-1] ^ bMod_s[DIGIT-1];
  end

  // Digit result select
  always_comb begin
    result = '0;
    case (op)
      OP_AND:         result = aMod_s & bMod_s;
      OP_OR:          result = aMod_s | bMod_s;
      OP_ADD, OP_SLT: result = sum_s[DIGIT-1:0];
      default:        result = sum_s[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: processes WIDTH bits DIGIT per clock with a registered inter-digit carry
// and a start/valid handshake.
module alu_digit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  state_t           state_r;
  state_t           nextState_s;
  logic [CW-1:0]    count_r;
  logic             carry_r;
  logic [WIDTH-1:0] opA_r;
  logic [WIDTH-1:0] opB_r;
  logic [3:0]       ctrl_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             cout_r;
  logic             ovf_r;
  logic             valid_r;
  logic             ready_r;

  logic             accept_s;
  logic             lastDigit_s;
  logic [1:0]       op_s;
  logic [DIGIT-1:0] digitRes_s;
  logic             carryOut_s;
  logic             carryTop_s;
  logic             ovfBit_s;
  logic [WIDTH-1:0] accNext_s;
  logic [WIDTH-1:0] resultNext_s;

  assign op_s        = ctrl_r[CTRL_OP_MSB:CTRL_OP_LSB];
  assign accept_s    = start_i & ready_r;
  assign lastDigit_s = (state_r == RUN) && (count_r == LAST_DIGIT);

  // Operands shift right each RUN cycle, so the active digit always sits in the low bits.
  alu_digit #(
    .DIGIT(DIGIT)
  ) uDigit (
    .a       (opA_r[DIGIT-1:0]),
    .b       (opB_r[DIGIT-1:0]),
    .invertA (ctrl_r[CTRL_INV_A]),
    .invertB (ctrl_r[CTRL_INV_B]),
    .op      (op_s),
    .carryIn (carry_r),
    .result  (digitRes_s),
    .carryOut(carryOut_s),
    .carryTop(carryTop_s)
  );

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) nextState_s = RUN;
        else          nextState_s = IDLE;
      end
      RUN: begin
        if (count_r == LAST_DIGIT) nextState_s = DONE;
        else                       nextState_s = RUN;
      end
      DONE: begin
        if (accept_s) nextState_s = RUN;
        else          nextState_s = IDLE;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Result assembly: new digit enters at the top while earlier digits move down
  always_comb begin
    ovfBit_s  = carryTop_s ^ carryOut_s;
    accNext_s = (acc_r >> DIGIT) | (WIDTH'(digitRes_s) << (WIDTH - DIGIT));
    resultNext_s = accNext_s;
    case (op_s)
      OP_SLT:                resultNext_s = WIDTH'(digitRes_s[DIGIT-1] ^ ovfBit_s);
      OP_AND, OP_OR, OP_ADD: resultNext_s = accNext_s;
      default:               resultNext_s = accNext_s;
    endcase
  end

  // State register; ready tracks "not in RUN" so it is available straight from a flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= nextState_s;
      ready_r <= (nextState_s != RUN);
    end
  end

  // Operand latch, digit counter, carry chain and result/flag capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opA_r    <= '0;
      opB_r    <= '0;
      ctrl_r   <= 4'b0000;
      count_r  <= '0;
      carry_r  <= 1'b0;
      acc_r    <= '0;
      result_r <= '0;
      zero_r   <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (accept_s) begin
        opA_r   <= src1_i;
        opB_r   <= src2_i;
        ctrl_r  <= ALU_control_i;
        count_r <= '0;
        // Inverted B plus carry-in of one forms the two's complement for SUB/SLT.
        carry_r <= ALU_control_i[CTRL_INV_B];
        acc_r   <= '0;
      end else if (state_r == RUN) begin
        opA_r   <= opA_r >> DIGIT;
        opB_r   <= opB_r >> DIGIT;
        acc_r   <= accNext_s;
        count_r <= count_r + CW'(1);
        carry_r <= isArith(op_s) ? carryOut_s : carry_r;
        if (lastDigit_s) begin
          result_r <= resultNext_s;
          zero_r   <= (resultNext_s == '0);
          cout_r   <= isArith(op_s) ? carryOut_s : 1'b0;
          ovf_r    <= isArith(op_s) ? ovfBit_s : 1'b0;
          valid_r  <= 1'b1;
        end
      end
    end
  end

  assign ready_o    = ready_r;
  assign valid_o    = valid_r;
  assign result_o   = result_r;
  assign zero_o     = zero_r;
  assign cout_o     = cout_r;
  assign overflow_o = ovf_r;

endmodule
